// File: rtl/telemetry_rx.sv
// Telemetry link receiver: 8N1 UART deserialiser plus a packet framer.
// It checks the AA 55 sync and the six payload bytes, then presents three 12-bit values.
module telemetry_rx #(
    parameter int BAUD_DIV = 2604,
    parameter int TIMEOUT  = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic [11:0] batt_v,
    output logic [11:0] avg_curr,
    output logic [11:0] avg_torque,
    output logic        pkt_rdy,
    output logic        pkt_err
);
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam logic [16:0]   TO   = 17'(TIMEOUT);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HI} rx_state_t;
    typedef enum logic [1:0] {PK_SYNC1, PK_SYNC2, PK_PAY} pk_state_t;

    logic            rx_meta, rxs, rxs_d;
    rx_state_t       rx_state, rx_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      bit_cnt, bit_nxt;
    logic [7:0]      shreg, sh_nxt;
    logic            byte_vld, fe;

    pk_state_t       pk_state, pk_nxt;
    logic [2:0]      idx, idx_nxt;
    logic [7:0]      shadow [0:5];
    logic [16:0]     tcnt;
    logic            timeout, store, load, rdy_nxt, err_nxt;

    // RX is asynchronous; the synchroniser and edge history idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= RX;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            rx_state <= rx_nxt;
            cnt      <= cnt_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= sh_nxt;
        end
    end

    always_comb begin
        rx_nxt   = rx_state;
        cnt_nxt  = cnt;
        bit_nxt  = bit_cnt;
        sh_nxt   = shreg;
        byte_vld = 1'b0;
        fe       = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                if (rxs_d && !rxs) begin
                    rx_nxt  = RX_START;
                    cnt_nxt = HALF;
                end
            end
            RX_START: begin
                if (cnt == '0) begin
                    if (!rxs) begin
                        rx_nxt  = RX_DATA;
                        cnt_nxt = FULL;
                        bit_nxt = '0;
                    end else begin
                        rx_nxt = RX_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt == '0) begin
                    sh_nxt  = {rxs, shreg[7:1]};
                    cnt_nxt = FULL;
                    if (bit_cnt == 3'd7) rx_nxt = RX_STOP;
                    else bit_nxt = bit_cnt + 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt == '0) begin
                    if (rxs) begin
                        byte_vld = 1'b1;
                        rx_nxt   = RX_IDLE;
                    end else begin
                        fe     = 1'b1;
                        rx_nxt = RX_WAIT_HI;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RX_WAIT_HI: begin
                if (rxs) rx_nxt = RX_IDLE;
            end
            default: rx_nxt = RX_IDLE;
        endcase
    end

    assign timeout = (pk_state != PK_SYNC1) && (tcnt == TO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_state   <= PK_SYNC1;
            idx        <= '0;
            tcnt       <= '0;
            pkt_rdy    <= 1'b0;
            pkt_err    <= 1'b0;
            batt_v     <= '0;
            avg_curr   <= '0;
            avg_torque <= '0;
            for (int unsigned i = 0; i < 6; i++) shadow[i] <= '0;
        end else begin
            pk_state <= pk_nxt;
            idx      <= idx_nxt;
            pkt_rdy  <= rdy_nxt;
            pkt_err  <= err_nxt;
            if (pk_state == PK_SYNC1 || byte_vld) tcnt <= '0;
            else if (tcnt != TO) tcnt <= tcnt + 1'b1;
            if (store) shadow[idx] <= shreg;
            // The last payload byte is taken straight from the shifter, since it lands in shadow on this same edge.
            if (load) begin
                batt_v     <= {shadow[0][3:0], shadow[1]};
                avg_curr   <= {shadow[2][3:0], shadow[3]};
                avg_torque <= {shadow[4][3:0], shreg};
            end
        end
    end

    always_comb begin
        pk_nxt  = pk_state;
        idx_nxt = idx;
        store   = 1'b0;
        load    = 1'b0;
        rdy_nxt = 1'b0;
        err_nxt = 1'b0;
        if (byte_vld) begin
            unique case (pk_state)
                PK_SYNC1: if (shreg == 8'hAA) pk_nxt = PK_SYNC2;
                PK_SYNC2: begin
                    if (shreg == 8'h55) begin
                        pk_nxt  = PK_PAY;
                        idx_nxt = '0;
                    end else if (shreg != 8'hAA) begin
                        pk_nxt  = PK_SYNC1;
                        err_nxt = 1'b1;
                    end
                end
                PK_PAY: begin
                    store   = 1'b1;
                    idx_nxt = idx + 1'b1;
                    if (idx == 3'd5) begin
                        pk_nxt = PK_SYNC1;
                        if ((shadow[0][7:4] | shadow[2][7:4] | shadow[4][7:4]) == 4'h0) begin
                            load    = 1'b1;
                            rdy_nxt = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
                default: pk_nxt = PK_SYNC1;
            endcase
        end else if ((fe || timeout) && pk_state != PK_SYNC1) begin
            pk_nxt  = PK_SYNC1;
            err_nxt = 1'b1;
        end
    end
endmodule
